// File: rtl/qa_drv_hc_channel_arbiter_if.sv
// rtl/qa_drv_hc_channel_arbiter_if.sv - requester/CCI-side signal bundle for the host-channel arbiter
//
// Groups every non-clock/reset signal of the arbiter.
//   slave  : arbiter side (takes requests, headers, data, back-pressure, rx0 credits;
//            drives grants, registered Tx0/Tx1 outputs and the outstanding-read count)
//   master : requester/CCI side, the mirror image
interface qa_drv_hc_channel_arbiter_if #(
    parameter int N_REQ = 3,
    parameter int HDR_W = 99,
    parameter int CNT_W = 7
);
    logic [N_REQ-1:0]       rd_req;
    logic [N_REQ*HDR_W-1:0] rd_hdr;
    logic [N_REQ-1:0]       wr_req;
    logic [N_REQ*HDR_W-1:0] wr_hdr;
    logic [N_REQ*512-1:0]   wr_data;
    logic [N_REQ-1:0]       rd_grant;
    logic [N_REQ-1:0]       wr_grant;
    logic                   tx0_almost_full;
    logic                   tx1_almost_full;
    logic [HDR_W-1:0]       tx0_hdr;
    logic                   tx0_rdvalid;
    logic [HDR_W-1:0]       tx1_hdr;
    logic [511:0]           tx1_data;
    logic                   tx1_wrvalid;
    logic                   rx0_rdvalid;
    logic [CNT_W-1:0]       rd_outstanding;

    modport slave (
        input  rd_req, rd_hdr, wr_req, wr_hdr, wr_data,
        input  tx0_almost_full, tx1_almost_full, rx0_rdvalid,
        output rd_grant, wr_grant,
        output tx0_hdr, tx0_rdvalid, tx1_hdr, tx1_data, tx1_wrvalid,
        output rd_outstanding
    );

    modport master (
        output rd_req, rd_hdr, wr_req, wr_hdr, wr_data,
        output tx0_almost_full, tx1_almost_full, rx0_rdvalid,
        input  rd_grant, wr_grant,
        input  tx0_hdr, tx0_rdvalid, tx1_hdr, tx1_data, tx1_wrvalid,
        input  rd_outstanding
    );
endinterface

// File: rtl/qa_drv_hc_channel_arbiter.sv
// rtl/qa_drv_hc_channel_arbiter.sv - round-robin sharing of CCI Tx0/Tx1 among host-channel requesters
//
// Ports:
//   clk      : clock
//   reset_n  : synchronous active-low reset
//   bus      : qa_drv_hc_channel_arbiter_if.slave
//              rd_req/rd_hdr, wr_req/wr_hdr/wr_data  per-requester requests (level)
//              rd_grant/wr_grant                     one-hot grants, same cycle as request
//              tx0_almost_full/tx1_almost_full        CCI back-pressure
//              tx0_hdr/tx0_rdvalid                    registered read request
//              tx1_hdr/tx1_data/tx1_wrvalid           registered write request
//              rx0_rdvalid                            read response, returns one credit
//              rd_outstanding                         reads in flight
// Requester 0 = status manager, 1 = FIFO-from-host, 2 = FIFO-to-host.
module qa_drv_hc_channel_arbiter #(
    parameter int N_REQ              = 3,
    parameter int HDR_W              = 99,
    parameter int MAX_RD_OUTSTANDING = 64,
    parameter int CNT_W              = $clog2(MAX_RD_OUTSTANDING + 1)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    qa_drv_hc_channel_arbiter_if.slave   bus
);

    localparam int               IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CNT_W-1:0] RD_MAX   = CNT_W'(MAX_RD_OUTSTANDING);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
    localparam logic [8:0]       SETTLE   = 9'd256;

    // First requester at or after ptr, scanning ascending with wrap.
    function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [IDX_W-1:0] ptr);
        logic [N_REQ-1:0] g;
        logic             done;
        int               j;
        g    = '0;
        done = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(ptr) + k) % N_REQ;
            if (!done && req[j[IDX_W-1:0]]) begin
                g[j[IDX_W-1:0]] = 1'b1;
                done            = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic logic [IDX_W-1:0] onehot_idx(input logic [N_REQ-1:0] g);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (g[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    logic [IDX_W-1:0] rd_ptr;
    logic [IDX_W-1:0] wr_ptr;
    logic [CNT_W-1:0] rd_cnt;
    logic [8:0]       settle_cnt;

    logic             rd_ok;
    logic             wr_ok;
    logic [N_REQ-1:0] rd_gnt;
    logic [N_REQ-1:0] wr_gnt;
    logic             rd_any;
    logic             wr_any;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [HDR_W-1:0] rd_hdr_sel;
    logic [HDR_W-1:0] wr_hdr_sel;
    logic [511:0]     wr_data_sel;

    logic [HDR_W-1:0] tx0_hdr_q;
    logic             tx0_rdvalid_q;
    logic [HDR_W-1:0] tx1_hdr_q;
    logic [511:0]     tx1_data_q;
    logic             tx1_wrvalid_q;

    always_comb begin
        // Credit check uses the registered count, so a response arriving this
        // cycle only frees a slot from the next cycle on.
        rd_ok       = reset_n && !bus.tx0_almost_full && (rd_cnt < RD_MAX);
        wr_ok       = reset_n && !bus.tx1_almost_full;
        rd_gnt      = rd_ok ? rr_pick(bus.rd_req, rd_ptr) : '0;
        wr_gnt      = wr_ok ? rr_pick(bus.wr_req, wr_ptr) : '0;
        rd_any      = |rd_gnt;
        wr_any      = |wr_gnt;
        rd_idx      = onehot_idx(rd_gnt);
        wr_idx      = onehot_idx(wr_gnt);
        rd_hdr_sel  = bus.rd_hdr[int'(rd_idx)*HDR_W +: HDR_W];
        wr_hdr_sel  = bus.wr_hdr[int'(wr_idx)*HDR_W +: HDR_W];
        wr_data_sel = bus.wr_data[int'(wr_idx)*512 +: 512];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            rd_cnt        <= '0;
            settle_cnt    <= '0;
            tx0_hdr_q     <= '0;
            tx0_rdvalid_q <= 1'b0;
            tx1_hdr_q     <= '0;
            tx1_data_q    <= '0;
            tx1_wrvalid_q <= 1'b0;
        end else begin
            if (settle_cnt != SETTLE) settle_cnt <= settle_cnt + 9'd1;

            tx0_rdvalid_q <= rd_any;
            if (rd_any) begin
                tx0_hdr_q <= rd_hdr_sel;
                rd_ptr    <= (rd_idx == LAST_IDX) ? '0 : rd_idx + 1'b1;
            end

            tx1_wrvalid_q <= wr_any;
            if (wr_any) begin
                tx1_hdr_q  <= wr_hdr_sel;
                tx1_data_q <= wr_data_sel;
                wr_ptr     <= (wr_idx == LAST_IDX) ? '0 : wr_idx + 1'b1;
            end

            // Grant and response together cancel; both ends clamp so a stale
            // response after reset cannot wrap the counter.
            case ({rd_any, bus.rx0_rdvalid})
                2'b10:   if (rd_cnt != RD_MAX) rd_cnt <= rd_cnt + 1'b1;
                2'b01:   if (rd_cnt != '0)     rd_cnt <= rd_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // Responses for reads issued before a reset may still trickle in for a
    // while, so underflow is only flagged once things have settled.
    always_ff @(posedge clk) begin
        if (reset_n && settle_cnt == SETTLE) begin
            assert (!(bus.rx0_rdvalid && rd_cnt == '0))
                else $error("rd_outstanding underflow: rx0_rdvalid with no reads in flight");
        end
    end

    assign bus.rd_grant       = rd_gnt;
    assign bus.wr_grant       = wr_gnt;
    assign bus.tx0_hdr        = tx0_hdr_q;
    assign bus.tx0_rdvalid    = tx0_rdvalid_q;
    assign bus.tx1_hdr        = tx1_hdr_q;
    assign bus.tx1_data       = tx1_data_q;
    assign bus.tx1_wrvalid    = tx1_wrvalid_q;
    assign bus.rd_outstanding = rd_cnt;

endmodule

// File: doc/qa_drv_hc_channel_arbiter.md
Name: qa_drv_hc_channel_arbiter

Overview:
Shares the CCI read (Tx0) and write (Tx1) request channels among the host-channel requesters: status manager, FIFO-from-host reader and FIFO-to-host writer.
- Read and write channels are arbitrated independently, round-robin per channel.
- Honours CCI almost-full back-pressure on both channels.
- Bounds outstanding line reads with a credit counter.
- Issues one-hot grants in the request cycle; drives registered Tx outputs one cycle later.

Parameters:
N_REQ, 3, number of requesters; index 0 = status manager, 1 = FIFO-from-host, 2 = FIFO-to-host.
HDR_W, 99, CCI request header width in bits.
MAX_RD_OUTSTANDING, 64, maximum line reads in flight; must be ≥1.
CNT_W, $clog2(MAX_RD_OUTSTANDING+1), outstanding-counter width.

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
rd_req  in  N_REQ  per-requester read request, level
rd_hdr  in  N_REQ*HDR_W  read headers, requester i at [i*HDR_W +: HDR_W]
wr_req  in  N_REQ  per-requester write request, level
wr_hdr  in  N_REQ*HDR_W  write headers, same packing as rd_hdr
wr_data  in  N_REQ*512  write line data, requester i at [i*512 +: 512]
rd_grant  out  N_REQ  one-hot read grant, combinational, same cycle as request
wr_grant  out  N_REQ  one-hot write grant, combinational, same cycle as request
tx0_almost_full  in  1  CCI Tx0 back-pressure
tx1_almost_full  in  1  CCI Tx1 back-pressure
tx0_hdr  out  HDR_W  registered read header
tx0_rdvalid  out  1  registered read valid
tx1_hdr  out  HDR_W  registered write header
tx1_data  out  512  registered write data
tx1_wrvalid  out  1  registered write valid
rx0_rdvalid  in  1  read response line arrived; returns one credit
rd_outstanding  out  CNT_W  current in-flight read count

Behaviour:
Reset (reset_n=0 at clk edge):
- tx0_rdvalid, tx1_wrvalid, rd_outstanding = 0.
- tx0_hdr, tx1_hdr, tx1_data = 0.
- Both round-robin pointers = 0.
- Grants are forced to 0 while reset_n=0.

Read eligibility:
- rd_ok = !tx0_almost_full && (rd_outstanding < MAX_RD_OUTSTANDING).
- If rd_ok=0, rd_grant=0.

Read selection:
- Among the set rd_req bits, pick the first index at or after rd_ptr, scanning ascending mod N_REQ.
- rd_grant = one-hot of that index; all zero if no request.

Read pointer:
- On a grant to index i, rd_ptr <= (i+1) mod N_REQ.
- Otherwise rd_ptr holds.

Write channel:
- Identical scheme using wr_ptr, wr_req and tx1_almost_full.
- No credit limit on writes.

Tx pipeline (1-cycle latency):
- Next cycle: tx0_rdvalid = |rd_grant and tx0_hdr = header of the granted requester.
- Same for tx1_wrvalid, tx1_hdr, tx1_data.
- With no grant, valid=0 and hdr/data hold their previous values.

Requester contract:
- A requester holds req asserted until it sees a grant; a granted request is consumed.
- A requester may deassert req only without a grant pending; the arbiter tolerates a req drop at any time.

Credit counter:
- +1 on a read grant, -1 on rx0_rdvalid.
- Both in the same cycle: unchanged.
- Saturates at MAX_RD_OUTSTANDING; this is unreachable because rd_ok blocks grants at the limit.

Underflow:
- rx0_rdvalid while rd_outstanding=0 (e.g. stale response after a mid-operation reset): counter stays 0.
- A simulation assertion fires, except during the first 256 cycles after reset deassertion.

Read/write independence:
- A requester may receive a read grant and a write grant in the same cycle.

Almost-full:
- almost_full sampled high blocks grants in that cycle only.
- Already-registered Tx outputs still issue next cycle; CCI almost-full slack covers this.

Test Plan:
- All three rd_req held high, no back-pressure, MAX=64 → rd_grant sequence 001,010,100,001 on consecutive cycles; tx0_rdvalid high from cycle 2 with the matching headers; rd_outstanding reaches 4 after 4 grants.
- MAX_RD_OUTSTANDING=2, rd_req[1] held, no responses → 2 grants, then rd_grant=0 with rd_outstanding=2. Pulse rx0_rdvalid → one grant in the following cycle.
- Grant and rx0_rdvalid in the same cycle with rd_outstanding=1 → count stays 1.
- tx1_almost_full=1 for 5 cycles with wr_req=3'b110 → wr_grant=0 throughout. On release, wr_grant=010 then 100. tx1_data equals wr_data[1*512 +: 512] one cycle after the grant.
- rd_req=001 and wr_req=001 together → rd_grant=001 and wr_grant=001 in the same cycle; both Tx valids high next cycle.
- Assert reset_n=0 with rd_outstanding=5 → counter, pointers and valids 0 next cycle. A following rx0_rdvalid within 256 cycles leaves count 0 with no assertion.
